// File: rtl/sync_stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_stream_fifo_pkg
// Purpose  : Shared types and elaboration-time helpers for sync_stream_fifo.
//            addr_w() gives the RAM address width for a given depth;
//            is_pow2() backs the parameter legality checks in the top level.
// Revision : 1.0 - initial release
// ============================================================================
package sync_stream_fifo_pkg;

    // Which register currently supplies the head entry on o_m_data.
    typedef enum logic {
        HEAD_BYP = 1'b0,   // written straight from the input (empty FIFO)
        HEAD_RAM = 1'b1    // read out of the storage RAM
    } head_src_e;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_stream_fifo_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_stream_fifo_sdp_ram
// Purpose  : Simple dual-port storage RAM: one write port, one read port with
//            a registered output. No reset, so it maps onto block RAM.
// Ports    : clk      - clock
//            i_we     - write enable,  i_waddr / i_wdata write address/data
//            i_re     - read enable,   i_raddr read address
//            o_rdata  - registered read data; holds while i_re is low
// Revision : 1.0 - initial release
// ============================================================================
module sync_stream_fifo_sdp_ram #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 512,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_stream_fifo
// Purpose  : Single-clock valid/ready FIFO with fill level, almost-full /
//            almost-empty flags and a selectable full policy: back-pressure
//            (OVERWRITE=0) or discard-oldest (OVERWRITE=1).
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            i_flush           - synchronous clear of all contents
//            i_s_data/i_s_valid/o_s_ready - write stream
//            o_m_data/o_m_valid/i_m_ready - read stream (head registered)
//            o_count           - entries held including the head, 0..DEPTH
//            o_almost_full     - o_count >= ALMOST_FULL
//            o_almost_empty    - o_count <= ALMOST_EMPTY
//            o_drop            - one-cycle pulse per entry lost to overwrite
//            o_drop_cnt        - saturating count of overwrite discards
// Revision : 1.0 - initial release
// ============================================================================
module sync_stream_fifo
    import sync_stream_fifo_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int WIDTH        = 512,
    parameter int OVERWRITE    = 0,
    parameter int ALMOST_FULL  = DEPTH - 4,
    parameter int ALMOST_EMPTY = 4,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_s_data,
    input  logic                   i_s_valid,
    output logic                   o_s_ready,
    output logic [WIDTH-1:0]       o_m_data,
    output logic                   o_m_valid,
    input  logic                   i_m_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_almost_full,
    output logic                   o_almost_empty,
    output logic                   o_drop,
    output logic [CNT_W-1:0]       o_drop_cnt
);

    localparam int              ADDR_W  = addr_w(DEPTH);
    localparam int              PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_AF    = PTR_W'(ALMOST_FULL);
    localparam logic [PTR_W-1:0] C_AE    = PTR_W'(ALMOST_EMPTY);
    localparam bit              C_OVR   = (OVERWRITE != 0);

    // ---------------- parameter legality ----------------
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_chk_depth
        $error("sync_stream_fifo: DEPTH must be a power of 2 and >= 4");
    end
    if (ALMOST_FULL < 0 || ALMOST_FULL > DEPTH) begin : g_chk_af
        $error("sync_stream_fifo: ALMOST_FULL must lie in 0..DEPTH");
    end
    if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH) begin : g_chk_ae
        $error("sync_stream_fifo: ALMOST_EMPTY must lie in 0..DEPTH");
    end
    if (CNT_W < 1) begin : g_chk_cnt
        $error("sync_stream_fifo: CNT_W must be >= 1");
    end

    // ---------------- state ----------------
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_count;
    logic             r_m_valid;
    head_src_e        r_head_src;
    logic [WIDTH-1:0] r_byp_data;
    logic             r_s_ready;
    logic             r_af;
    logic             r_ae;
    logic             r_drop;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_ovr;
    logic             w_adv;
    logic             w_head_free;
    logic             w_ram_empty;
    logic             w_ram_full;
    logic             w_re;
    logic             w_byp;
    logic             w_we;
    logic [PTR_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_ram_rdata;

    // RAM occupancy excludes the head register; pointers carry a wrap bit.
    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_ram_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                         (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    assign w_push = i_s_valid & r_s_ready & ~i_flush;
    assign w_pop  = r_m_valid & i_m_ready & ~i_flush;
    // Overwrite: a push at full with no pop retires the head as if popped.
    assign w_ovr  = C_OVR & w_push & ~w_pop & (r_count == C_DEPTH);
    assign w_adv  = w_pop | w_ovr;

    // Prefetch: refill the head from RAM whenever it is empty or leaving.
    // If the RAM has nothing, an incoming push goes straight to the head.
    assign w_head_free = ~r_m_valid | w_adv;
    assign w_re        = w_head_free & ~w_ram_empty & ~i_flush;
    assign w_byp       = w_head_free & w_ram_empty & w_push;
    assign w_we        = w_push & ~w_byp & ~w_ram_full;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_adv) begin
            w_count_nxt = r_count + PTR_W'(1);
        end else if (!w_push && w_adv) begin
            w_count_nxt = r_count - PTR_W'(1);
        end
    end

    sync_stream_fifo_sdp_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (i_s_data),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_m_valid  <= 1'b0;
            r_head_src <= HEAD_BYP;
            r_byp_data <= '0;
            r_s_ready  <= 1'b0;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else if (i_flush) begin
            // Contents already in RAM become unreachable by catching up.
            r_rd_ptr   <= r_wr_ptr;
            r_count    <= '0;
            r_m_valid  <= 1'b0;
            r_s_ready  <= 1'b1;
            r_af       <= (PTR_W'(0) >= C_AF);
            r_ae       <= 1'b1;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count   <= w_count_nxt;
            r_af      <= (w_count_nxt >= C_AF);
            r_ae      <= (w_count_nxt <= C_AE);
            r_s_ready <= C_OVR | (w_count_nxt != C_DEPTH);

            if (w_re) begin
                r_m_valid  <= 1'b1;
                r_head_src <= HEAD_RAM;
            end else if (w_byp) begin
                r_m_valid  <= 1'b1;
                r_head_src <= HEAD_BYP;
                r_byp_data <= i_s_data;
            end else if (w_adv) begin
                r_m_valid  <= 1'b0;
            end

            r_drop <= w_ovr;
            if (w_ovr && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    // Both candidates are registers, so the head never sees s_* combinationally.
    assign o_m_data       = (r_head_src == HEAD_RAM) ? w_ram_rdata : r_byp_data;
    assign o_m_valid      = r_m_valid;
    assign o_s_ready      = r_s_ready;
    assign o_count        = r_count;
    assign o_almost_full  = r_af;
    assign o_almost_empty = r_ae;
    assign o_drop         = r_drop;
    assign o_drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sync_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_stream_fifo
// Purpose  : Self-checking bench for sync_stream_fifo. Two instances are
//            exercised: index 0 with back-pressure, index 1 with overwrite.
//            Directed sequences drive stimulus; per-instance monitors keep a
//            reference queue and compare the head, level, flags and drop
//            outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_stream_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             flush    [2];
    logic [WIDTH-1:0] s_data   [2];
    logic             s_valid  [2];
    logic             s_ready  [2];
    logic [WIDTH-1:0] m_data   [2];
    logic             m_valid  [2];
    logic             m_ready  [2];
    logic [3:0]       count    [2];
    logic             af       [2];
    logic             ae       [2];
    logic             drop     [2];
    logic [CNT_W-1:0] drop_cnt [2];

    int n_chk  = 0;
    int n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sync_stream_fifo #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .OVERWRITE(0),
        .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .CNT_W(CNT_W)
    ) u_dut0 (
        .clk(clk), .rst(rst), .i_flush(flush[0]),
        .i_s_data(s_data[0]), .i_s_valid(s_valid[0]), .o_s_ready(s_ready[0]),
        .o_m_data(m_data[0]), .o_m_valid(m_valid[0]), .i_m_ready(m_ready[0]),
        .o_count(count[0]), .o_almost_full(af[0]), .o_almost_empty(ae[0]),
        .o_drop(drop[0]), .o_drop_cnt(drop_cnt[0])
    );

    sync_stream_fifo #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .OVERWRITE(1),
        .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .CNT_W(CNT_W)
    ) u_dut1 (
        .clk(clk), .rst(rst), .i_flush(flush[1]),
        .i_s_data(s_data[1]), .i_s_valid(s_valid[1]), .o_s_ready(s_ready[1]),
        .o_m_data(m_data[1]), .o_m_valid(m_valid[1]), .i_m_ready(m_ready[1]),
        .o_count(count[1]), .o_almost_full(af[1]), .o_almost_empty(ae[1]),
        .o_drop(drop[1]), .o_drop_cnt(drop_cnt[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors / scoreboards ----------------
    for (genvar k = 0; k < 2; k++) begin : g_mon
        logic [WIDTH-1:0] q [$];
        bit               live;
        bit               e_drop;
        logic [CNT_W-1:0] e_dc;
        int               sz;

        initial begin
            live   = 1'b0;
            e_drop = 1'b0;
            e_dc   = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    q.delete();
                    live   = 1'b0;
                    e_drop = 1'b0;
                    e_dc   = '0;
                end else begin
                    sz = q.size();
                    if (live) begin
                        chk($sformatf("dut%0d count", k), 64'(count[k]), 64'(sz));
                        chk($sformatf("dut%0d m_valid", k), 64'(m_valid[k]), 64'(sz != 0));
                        if (sz != 0) begin
                            chk($sformatf("dut%0d m_data", k), 64'(m_data[k]), 64'(q[0]));
                        end
                        chk($sformatf("dut%0d almost_full", k), 64'(af[k]), 64'(sz >= AF));
                        chk($sformatf("dut%0d almost_empty", k), 64'(ae[k]), 64'(sz <= AE));
                        chk($sformatf("dut%0d s_ready", k), 64'(s_ready[k]),
                            64'((k == 1) || (sz != DEPTH)));
                        chk($sformatf("dut%0d drop", k), 64'(drop[k]), 64'(e_drop));
                        chk($sformatf("dut%0d drop_cnt", k), 64'(drop_cnt[k]), 64'(e_dc));
                    end
                    // Predict the effect of the coming edge.
                    e_drop = 1'b0;
                    if (flush[k]) begin
                        q.delete();
                        e_dc = '0;
                    end else begin
                        if (m_valid[k] && m_ready[k] && q.size() != 0) begin
                            void'(q.pop_front());
                        end
                        if (s_valid[k] && s_ready[k]) begin
                            if (q.size() == DEPTH) begin
                                void'(q.pop_front());
                                e_drop = 1'b1;
                                if (e_dc != '1) e_dc = e_dc + 1'b1;
                            end
                            q.push_back(s_data[k]);
                        end
                    end
                    live = 1'b1;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int k, input int first, input int n, output int drops);
        drops = 0;
        for (int i = 0; i < n; i++) begin
            s_valid[k] = 1'b1;
            s_data[k]  = WIDTH'(first + i);
            cyc();
            if (drop[k]) drops++;
        end
        s_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        m_ready[k] = 1'b1;
        while (m_valid[k] && t < 40) begin
            cyc();
            t++;
        end
        chk($sformatf("dut%0d drain ends empty", k), 64'(m_valid[k]), 64'd0);
        m_ready[k] = 1'b0;
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("dut%0d rst count", k), 64'(count[k]), 64'd0);
        chk($sformatf("dut%0d rst m_valid", k), 64'(m_valid[k]), 64'd0);
        chk($sformatf("dut%0d rst m_data", k), 64'(m_data[k]), 64'd0);
        chk($sformatf("dut%0d rst s_ready", k), 64'(s_ready[k]), 64'd0);
        chk($sformatf("dut%0d rst almost_empty", k), 64'(ae[k]), 64'd1);
        chk($sformatf("dut%0d rst almost_full", k), 64'(af[k]), 64'd0);
        chk($sformatf("dut%0d rst drop", k), 64'(drop[k]), 64'd0);
        chk($sformatf("dut%0d rst drop_cnt", k), 64'(drop_cnt[k]), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            flush[k]   = 1'b0;
            s_valid[k] = 1'b0;
            s_data[k]  = '0;
            m_ready[k] = 1'b0;
        end
        #1;
        chk_reset(0);
        chk_reset(1);
        repeat (2) cyc();
        rst = 1'b0;
        chk("dut0 s_ready before first edge", 64'(s_ready[0]), 64'd0);
        cyc();
        chk("dut0 s_ready after release", 64'(s_ready[0]), 64'd1);
        chk("dut1 s_ready after release", 64'(s_ready[1]), 64'd1);

        // 1: first-push latency and level
        s_valid[0] = 1'b1;
        s_data[0]  = 32'd1;
        cyc();
        s_valid[0] = 1'b0;
        chk("t1 m_valid after 1st push", 64'(m_valid[0]), 64'd1);
        chk("t1 m_data after 1st push", 64'(m_data[0]), 64'd1);
        push_seq(0, 2, 2, d);
        chk("t1 count", 64'(count[0]), 64'd3);
        chk("t1 m_data held", 64'(m_data[0]), 64'd1);
        drain(0);
        chk("t1 almost_empty", 64'(ae[0]), 64'd1);

        // 2: back-pressure at full
        push_seq(0, 1, 10, d);
        chk("t2 s_ready at full", 64'(s_ready[0]), 64'd0);
        chk("t2 count at full", 64'(count[0]), 64'd8);
        chk("t2 almost_full", 64'(af[0]), 64'd1);
        chk("t2 head", 64'(m_data[0]), 64'd1);
        chk("t2 drop stays 0", 64'(drop_cnt[0]), 64'd0);
        drain(0);
        chk("t2 count drained", 64'(count[0]), 64'd0);
        chk("t2 almost_empty", 64'(ae[0]), 64'd1);

        // 3: overwrite mode, push+pop at full is an exchange
        push_seq(1, 1, 8, d);
        chk("t3 count full", 64'(count[1]), 64'd8);
        s_valid[1] = 1'b1;
        s_data[1]  = 32'd9;
        m_ready[1] = 1'b1;
        cyc();
        s_valid[1] = 1'b0;
        m_ready[1] = 1'b0;
        chk("t3 count after exchange", 64'(count[1]), 64'd8);
        chk("t3 head after exchange", 64'(m_data[1]), 64'd2);
        chk("t3 no drop", 64'(drop[1]), 64'd0);
        chk("t3 drop_cnt", 64'(drop_cnt[1]), 64'd0);
        drain(1);

        // 4: overwrite discards oldest
        push_seq(1, 1, 11, d);
        chk("t4 drop pulses", 64'(d), 64'd3);
        chk("t4 drop_cnt", 64'(drop_cnt[1]), 64'd3);
        chk("t4 count", 64'(count[1]), 64'd8);
        chk("t4 head", 64'(m_data[1]), 64'd4);
        drain(1);
        flush[1] = 1'b1;
        cyc();
        flush[1] = 1'b0;
        chk("t4 flush clears drop_cnt", 64'(drop_cnt[1]), 64'd0);

        // 5: flush while streaming
        push_seq(0, 1, 4, d);
        chk("t5 half full", 64'(count[0]), 64'd4);
        m_ready[0] = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = 32'd5;
        cyc();
        s_data[0]  = 32'd6;
        cyc();
        flush[0]   = 1'b1;
        s_data[0]  = 32'hDEAD;
        cyc();
        flush[0]   = 1'b0;
        s_valid[0] = 1'b0;
        chk("t5 count after flush", 64'(count[0]), 64'd0);
        chk("t5 m_valid after flush", 64'(m_valid[0]), 64'd0);
        repeat (3) cyc();
        chk("t5 flushed data absent", 64'(m_valid[0]), 64'd0);
        m_ready[0] = 1'b0;

        // 6: asynchronous reset mid-burst
        push_seq(1, 50, 10, d);
        s_valid[0] = 1'b1;
        s_data[0]  = 32'd77;
        s_valid[1] = 1'b1;
        s_data[1]  = 32'd78;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        chk_reset(0);
        chk_reset(1);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("t6 dut0 s_ready 1st edge", 64'(s_ready[0]), 64'd1);
        chk("t6 dut1 s_ready 1st edge", 64'(s_ready[1]), 64'd1);

        // Random soak against the reference queues.
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                s_valid[k] = ($urandom_range(0, 99) < 60);
                s_data[k]  = $urandom;
                m_ready[k] = ($urandom_range(0, 99) < 50);
                flush[k]   = ($urandom_range(0, 199) == 0);
            end
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0;
            flush[k]   = 1'b0;
        end
        drain(0);
        drain(1);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
